regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with same-cycle
// write-to-read bypass, a per-register busy scoreboard for hazard detection,
// synchronous clear, and a registered write-collision flag.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic                wr_collision
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             coll_q, coll_d;

  // Unpacked views of the write and read buses.
  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];
  logic [NWR-1:0]  wr_eff;
  logic [AW-1:0]   ra   [NRD];
  logic            alloc_eff;

  // Split the write buses and qualify each port as an effective write.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_eff = '0;
    for (int j = 0; j < NWR; j++) begin
      wa[j]     = wr_addr[j*AW +: AW];
      wd[j]     = wr_data[j*XLEN +: XLEN];
      wr_eff[j] = wr_en[j] && !rst && !(HAS_ZERO && (wa[j] == '0));
    end
    alloc_eff = alloc_en && !rst && !(HAS_ZERO && (alloc_addr == '0));
  end

  // Next state: writes in ascending port order (highest index wins), then
  // allocation on top so a same-cycle alloc keeps the register pending.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    coll_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff[j]) begin
        regs_d[wa[j]] = wd[j];
        busy_d[wa[j]] = 1'b0;
      end
    end
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_eff[i] && wr_eff[j] && (wa[i] == wa[j])) coll_d = 1'b1;
      end
    end
    if (alloc_eff) busy_d[alloc_addr] = 1'b1;
  end

  // State update with synchronous clear of storage, scoreboard and flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the storage array is reset explicitly; it is built from flops, so every register reads a defined value after reset.
      regs_q <= '{default: '0};
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      coll_q <= coll_d;
    end
  end

  // Combinational read ports with write-data and write-clear bypass.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra[k] = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = regs_q[ra[k]];
      rd_busy[k]              = busy_q[ra[k]] && !rst;
      for (int j = 0; j < NWR; j++) begin
        if (wr_eff[j] && (wa[j] == ra[k])) begin
          rd_data[k*XLEN +: XLEN] = wd[j];
          rd_busy[k]              = 1'b0;
        end
      end
      if (HAS_ZERO && (ra[k] == '0)) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end
    end
  end

  assign wr_collision = coll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors for regfile_mp. One instance has a hardwired
// zero register, a second shares all inputs with register 0 as plain storage.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    rd_addr;
  logic [63:0]   rd_data, rd_data_nz;
  logic [1:0]    rd_busy, rd_busy_nz;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [63:0]   wr_data;
  logic          alloc_en;
  logic [4:0]    alloc_addr;
  logic          wr_collision, wr_collision_nz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wr_collision(wr_collision)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .rd_busy(rd_busy_nz), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wr_collision(wr_collision_nz)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        al;
    logic [4:0]  aa;
    logic [4:0]  ra0, ra1;
    logic [31:0] d0, d1;
    logic [1:0]  busy;
    logic        coll;
    logic [31:0] nz_d0;
    logic        nz_b0;
    logic        nz_coll;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
  endtask

  // Drive inputs just after the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6,
                 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 5'd0, 5'd0, 32'h12345678, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h12345678, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h12345678, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h22222222, 32'h22222222, 2'b00, 1'b0, 32'h22222222, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h22222222, 32'h22222222, 2'b00, 1'b1, 32'h22222222, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h22222222, 32'h22222222, 2'b00, 1'b0, 32'h22222222, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7,
                 32'h0, 32'h22222222, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7,
                 32'h0, 32'h22222222, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 5'd3, 5'd0, 32'h5A5A5A5A, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3,
                 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b11, 1'b0, 32'h5A5A5A5A, 1'b1, 1'b0};
    vecs[13] = '{2'b11, 5'd0, 5'd0, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0, 32'hBBBBBBBB, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0, 32'hBBBBBBBB, 1'b0, 1'b1};
    vecs[15] = '{2'b11, 5'd10, 5'd11, 32'h10, 32'h11, 1'b0, 5'd0, 5'd10, 5'd11,
                 32'h10, 32'h11, 2'b00, 1'b0, 32'h10, 1'b0, 1'b0};

    // Reset for one edge.
    idle();
    rst = 1'b1;
    step();
    idle();

    // Every address reads zero, not busy, no collision after reset.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      check($sformatf("rst_d0[%0d]", a), rd_data[31:0], 32'h0);
      check($sformatf("rst_d1[%0d]", 31 - a), rd_data[63:32], 32'h0);
      check($sformatf("rst_busy[%0d]", a), {30'h0, rd_busy}, 32'h0);
      check($sformatf("rst_nz_d0[%0d]", a), rd_data_nz[31:0], 32'h0);
    end
    check("rst_coll", {31'h0, wr_collision}, 32'h0);

    // Directed vectors, one per cycle.
    for (int i = 0; i < 16; i++) begin
      step();
      wr_en      = vecs[i].we;
      wr_addr    = {vecs[i].wa1, vecs[i].wa0};
      wr_data    = {vecs[i].wd1, vecs[i].wd0};
      alloc_en   = vecs[i].al;
      alloc_addr = vecs[i].aa;
      rd_addr    = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d_d0", i), rd_data[31:0], vecs[i].d0);
      check($sformatf("v%0d_d1", i), rd_data[63:32], vecs[i].d1);
      check($sformatf("v%0d_busy", i), {30'h0, rd_busy}, {30'h0, vecs[i].busy});
      check($sformatf("v%0d_coll", i), {31'h0, wr_collision}, {31'h0, vecs[i].coll});
      check($sformatf("v%0d_nz_d0", i), rd_data_nz[31:0], vecs[i].nz_d0);
      check($sformatf("v%0d_nz_b0", i), {31'h0, rd_busy_nz[0]}, {31'h0, vecs[i].nz_b0});
      check($sformatf("v%0d_nz_coll", i), {31'h0, wr_collision_nz}, {31'h0, vecs[i].nz_coll});
    end

    // Fill registers 1..31 with their index.
    for (int a = 1; a < 32; a++) begin
      step();
      idle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'(a)};
      wr_data = {32'h0, 32'(a)};
    end
    step();
    idle();
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      check($sformatf("fill_d0[%0d]", a), rd_data[31:0], 32'(a));
    end

    // Allocate 9 together with a colliding pair of writes to 12.
    step();
    idle();
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    wr_en      = 2'b11;
    wr_addr    = {5'd12, 5'd12};
    wr_data    = {32'd12, 32'd12};
    step();
    idle();
    rd_addr = {5'd12, 5'd9};
    #1;
    check("pre_rst_busy9", {31'h0, rd_busy[0]}, 32'h1);
    check("pre_rst_d12", rd_data[63:32], 32'd12);
    check("pre_rst_coll", {31'h0, wr_collision}, 32'h1);

    // Reset with an in-flight write and allocation: bypass off, busy reads 0.
    step();
    idle();
    rst        = 1'b1;
    wr_en      = 2'b01;
    wr_addr    = {5'd0, 5'd4};
    wr_data    = {32'h0, 32'hFFFFFFFF};
    alloc_en   = 1'b1;
    alloc_addr = 5'd4;
    rd_addr    = {5'd9, 5'd4};
    #1;
    check("in_rst_d4_no_bypass", rd_data[31:0], 32'd4);
    check("in_rst_busy", {30'h0, rd_busy}, 32'h0);

    step();
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      check($sformatf("post_rst_d[%0d]", a), rd_data[31:0], 32'h0);
      check($sformatf("post_rst_busy[%0d]", a), {30'h0, rd_busy}, 32'h0);
    end
    check("post_rst_coll", {31'h0, wr_collision}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
